// File: rtl/sram_req_responder.sv
// sram_req_responder: valid/ready request port onto a 16-word register
// array, one response per request returned through a 2-entry FIFO.
module sram_req_responder #(
  parameter int DW        = 4,
  parameter int AW        = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_wr,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data
);

  localparam int DEPTH = 1 << AW;
  localparam int EW    = 1 + AW + DW;
  localparam int PW    = $clog2(RSP_DEPTH);
  localparam int CW    = $clog2(RSP_DEPTH + 1);

  logic [DW-1:0] mem  [DEPTH];
  logic [EW-1:0] rbuf [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [DW-1:0] rd_word;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;

  // Ready depends only on fill level, never on rsp_ready.
  assign req_ready = !rst && (count != CW'(RSP_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Reads capture the array content before the accept edge.
  assign rd_word = mem[req_addr];
  assign entry   = {req_wr, req_addr, req_wr ? req_data : rd_word};

  // Outputs come only from the FIFO head; zeroed when empty.
  assign head      = rbuf[rd_ptr];
  assign rsp_valid = (count != '0);
  assign {rsp_wr, rsp_addr, rsp_data} = rsp_valid ? head : '0;

  // Storage array: cleared on reset, written on accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && req_wr) begin
      mem[req_addr] <= req_data;
    end
  end

  // Response entries: written at the tail on every accept.
  always_ff @(posedge clk) begin
    if (push) begin
      rbuf[wr_ptr] <= entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_responder.sv
// tb_sram_req_responder: directed scenarios plus a random run
// against a queue scoreboard and a memory model.
module tb_sram_req_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [3:0] req_addr;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_wr;
  logic [3:0] rsp_addr;
  logic [3:0] rsp_data;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q [$];
  logic [3:0] model [16];

  always #5 clk = ~clk;

  sram_req_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 4'h0;
    req_data  = 4'h0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'd5;
    req_data  = 4'hF;
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low got %b exp 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_low got %b exp 0", rsp_valid);
    end
    cyc();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b exp 1", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_wr, rsp_addr, rsp_data} !== 10'h0) begin
      errors++;
      $display("FAIL post_reset_rsp got %h exp 000",
               {rsp_valid, rsp_wr, rsp_addr, rsp_data});
    end
  endtask

  task automatic test_reset_read();
    cyc();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 4'd5;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL read5_pre got %b exp 10", {req_ready, rsp_valid});
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_wr, rsp_addr, rsp_data} !== {2'b10, 4'd5, 4'h0}) begin
      errors++;
      $display("FAIL read5_rsp got %h exp %h",
               {rsp_valid, rsp_wr, rsp_addr, rsp_data}, {2'b10, 4'd5, 4'h0});
    end
    cyc();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read5_drain got %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp [3];
    exp[0] = {2'b11, 4'd3, 4'hA};
    exp[1] = {2'b10, 4'd3, 4'hA};
    exp[2] = 10'h0;
    cyc();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'd3;
    req_data  = 4'hA;
    cyc();
    model[3] = 4'hA;
    req_wr   = 1'b0;
    req_data = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_wr, rsp_addr, rsp_data} !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d got %h exp %h", i,
                 {rsp_valid, rsp_wr, rsp_addr, rsp_data}, exp[i]);
      end
      cyc();
      idle();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a [3];
    logic [3:0] d [3];
    logic [8:0] e;
    a[0] = 4'd1; a[1] = 4'd2; a[2] = 4'd4;
    d[0] = 4'hC; d[1] = 4'hD; d[2] = 4'hE;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = a[i];
      req_data  = d[i];
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept_%0d got %b exp 1", i, req_ready);
      end
      exp_q.push_back({1'b1, a[i], d[i]});
      model[a[i]] = d[i];
      cyc();
    end
    req_addr = a[2];
    req_data = d[2];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_addr} !== {2'b01, a[0]}) begin
        errors++;
        $display("FAIL bp_stall_%0d got %h exp %h", i,
                 {req_ready, rsp_valid, rsp_addr}, {2'b01, a[0]});
      end
      cyc();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (req_valid || exp_q.size() != 0); c++) begin
      logic acc;
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got %h exp none",
                   {rsp_wr, rsp_addr, rsp_data});
        end else begin
          e = exp_q.pop_front();
          if ({rsp_wr, rsp_addr, rsp_data} !== e) begin
            errors++;
            $display("FAIL bp_order got %h exp %h",
                     {rsp_wr, rsp_addr, rsp_data}, e);
          end
        end
      end
      acc = req_valid && req_ready;
      if (acc) begin
        checks++;
        if (c != 1) begin
          errors++;
          $display("FAIL bp_reopen got cycle %0d exp 1", c);
        end
        exp_q.push_back({1'b1, req_addr, req_data});
        model[req_addr] = req_data;
      end
      cyc();
      if (acc) idle();
    end
    checks++;
    if (req_valid || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout got pending %0d exp 0", exp_q.size());
      exp_q.delete();
      idle();
    end
  endtask

  task automatic test_boundary();
    logic [9:0] op  [4];
    logic [9:0] exp [4];
    op[0]  = {2'b11, 4'd15, 4'h7};
    op[1]  = {2'b11, 4'd0,  4'h9};
    op[2]  = {2'b10, 4'd15, 4'h0};
    op[3]  = {2'b10, 4'd0,  4'h0};
    exp[0] = {2'b11, 4'd15, 4'h7};
    exp[1] = {2'b11, 4'd0,  4'h9};
    exp[2] = {2'b10, 4'd15, 4'h7};
    exp[3] = {2'b10, 4'd0,  4'h9};
    cyc();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        {req_valid, req_wr, req_addr, req_data} = op[i];
      end else begin
        idle();
      end
      if (i > 0) begin
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_wr, rsp_addr, rsp_data} !== exp[i-1]) begin
          errors++;
          $display("FAIL bound_%0d got %h exp %h", i - 1,
                   {rsp_valid, rsp_wr, rsp_addr, rsp_data}, exp[i-1]);
        end
      end
      cyc();
    end
    model[15] = 4'h7;
    model[0]  = 4'h9;
  endtask

  task automatic test_reset_mid();
    cyc();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'd3;
    req_data  = 4'h5;
    cyc();
    req_addr  = 4'd6;
    req_data  = 4'h6;
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL mid_full got %b exp 10", {rsp_valid, req_ready});
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_flushed got %b exp 01", {rsp_valid, req_ready});
    end
    cyc();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 4'd3;
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_wr, rsp_addr, rsp_data} !== {2'b10, 4'd3, 4'h0}) begin
      errors++;
      $display("FAIL mid_read3 got %h exp %h",
               {rsp_valid, rsp_wr, rsp_addr, rsp_data}, {2'b10, 4'd3, 4'h0});
    end
    cyc();
  endtask

  task automatic test_random();
    int issued = 0;
    logic [8:0] e;
    logic acc;
    idle();
    for (int c = 0; c < 8000 && (issued < 1000 || req_valid ||
                                 exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra got %h exp none",
                   {rsp_wr, rsp_addr, rsp_data});
        end else begin
          e = exp_q.pop_front();
          if ({rsp_wr, rsp_addr, rsp_data} !== e) begin
            errors++;
            $display("FAIL rnd_rsp got %h exp %h",
                     {rsp_wr, rsp_addr, rsp_data}, e);
          end
        end
      end
      acc = req_valid && req_ready;
      if (acc) begin
        issued++;
        if (req_wr) begin
          exp_q.push_back({1'b1, req_addr, req_data});
          model[req_addr] = req_data;
        end else begin
          exp_q.push_back({1'b0, req_addr, model[req_addr]});
        end
      end
      cyc();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid || acc) begin
        if (issued < 1000 && $urandom_range(0, 4) != 0) begin
          req_valid = 1'b1;
          req_wr    = 1'($urandom_range(0, 1));
          req_addr  = 4'($urandom_range(0, 15));
          req_data  = 4'($urandom_range(0, 15));
        end else begin
          idle();
        end
      end
    end
    checks++;
    if (issued != 1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_done got issued %0d pending %0d exp 1000 0",
               issued, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_read();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
